vx_mem_responder: RTL
=====================

// Module: vx_mem_responder
// PURPOSE
//  Memory-side endpoint of the Vortex mem req/rsp bus: accepts line requests (rw, addr, byteen, data, tag),
//  services them from internal storage after a fixed latency, returns in-order tagged read responses.
//  Sits at the DST side of width adapters/arbiters in unit benches and FPGA-less sims; replaces external DRAM.
// PARAMETERS
//  DATA_WIDTH     512  line width in bits (multiple of 8)
//  ADDR_WIDTH     26   line address width
//  TAG_WIDTH      8    request tag width, returned verbatim
//  NUM_LINES      1024 storage depth (power of 2, <= 2**ADDR_WIDTH)
//  LATENCY        4    acceptance-to-earliest-response cycles (>= 1)
//  RSP_QUEUE_SIZE 8    max outstanding responses (power of 2, >= 2)
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high reset
//  mem_req_valid  in   1               request valid
//  mem_req_addr   in   ADDR_WIDTH      line address
//  mem_req_rw     in   1               1=write, 0=read
//  mem_req_byteen in   DATA_WIDTH/8    write byte enables
//  mem_req_data   in   DATA_WIDTH      write data
//  mem_req_tag    in   TAG_WIDTH       request tag
//  mem_req_ready  out  1               request accepted when valid&&ready
//  mem_rsp_valid  out  1               response valid
//  mem_rsp_data   out  DATA_WIDTH      read data
//  mem_rsp_tag    out  TAG_WIDTH       tag of originating request
//  mem_rsp_ready  in   1               response consumed when valid&&ready
//  pending        out  log2(RSP_QUEUE_SIZE)+1  outstanding responses (in pipe + queue)
// BEHAVIOUR
//  - Index = addr[log2(NUM_LINES)-1:0]; upper addr bits ignored (aliasing intended).
//  - Write fire: bytes with byteen=1 updated at that edge; byteen=0 bytes keep old value.
//  - Read fire: line sampled in the fire cycle (sees all writes fired in earlier cycles), pushed with tag
//    into LATENCY-deep valid/data pipe, then into RSP_QUEUE_SIZE FWFT queue.
//  - Latency: read fired at cycle t -> mem_rsp_valid=1 at cycle t+LATENCY if queue empty; else after older rsps.
//  - Strict in-order responses; rsp payload held stable while valid&&!ready.
//  - Credits: pending += read fire, -= rsp fire; simultaneous fire -> unchanged.
//  - mem_req_ready = (pending < RSP_QUEUE_SIZE) from registered state only; no comb path from mem_rsp_ready.
//  - Full: pending==RSP_QUEUE_SIZE -> ready=0, no request lost, no queue overflow.
//  - Empty: mem_rsp_valid=0, data/tag don't-care.
//  - Pipe never stalls; credits guarantee queue space on exit.
//  - Reset (any time, incl. mid-burst): pipe valids, queue, pending cleared next edge; in-flight rsps dropped;
//    storage NOT reset. Outputs after reset: mem_req_ready=1, mem_rsp_valid=0, pending=0.
//  - Write without macro: consumes no credit, produces no response.
// CONFIGURATION
//  VX_MEM_RESPONDER_WRITE_ACK_EN defined: each write also enters pipe, consumes a credit, returns a rsp
//    with its tag and mem_rsp_data='0, ordered with reads.
//  Undefined: writes are posted (no rsp, no credit); ack logic absent.
// STRUCTURE
//  - Shared package: rsp entry typedef {data, tag}; localparams for index width and pending width.
//  - One sub-module vx_mem_rsp_pipe: LATENCY-stage valid+entry shift pipe (reset clears valids only).
//  - Queue is the existing codebase FIFO; storage is plain reg array with per-byte write.
// TESTING
//  1 reset, write 0x100 all-ones byteen data=A, read 0x100 tag 0x11 -> rsp A tag 0x11 exactly 4 cyc after read fire.
//  2 write 0x5 data=0, then byteen=0x...0001 data=0xFF -> read returns 0x...00FF only.
//  3 rsp_ready=0, issue 10 reads -> 8 accepted, ready=0, pending=8; release -> 8 rsps in order, then 2 more accepted.
//  4 read 0x400 after write 0x000 (NUM_LINES=1024) -> returns write data (aliasing).
//  5 reset with 5 rsps pending -> next cycle valid=0, pending=0, ready=1; prior writes still readable.
//  6 macro on: write tag 0x22 then read tag 0x23 -> rsps tag 0x22 (data 0) then 0x23; macro off: only 0x23.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// vx_mem_responder_pkg
//   Shared definitions for the memory responder and its response pipe.
//   Holds the elaboration-time helpers that size the storage index and the
//   outstanding-response counter. The response entry layout ({data, tag}) is
//   declared in the top module because its field widths come from the top's
//   parameters.
//   Optional feature macro used by the responder: VX_MEM_RESPONDER_WRITE_ACK_EN
// ----------------------------------------------------------------------------
package vx_mem_responder_pkg;

  // Width of the line index taken from the low address bits.
  function automatic int vx_idx_width(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  // Width of the outstanding-response counter. It must be able to hold the
  // value queue_size itself, so it is one bit wider than log2(queue_size).
  function automatic int vx_pend_width(input int queue_size);
    return $clog2(queue_size) + 1;
  endfunction

endpackage

// File: rtl/vx_mem_rsp_pipe.sv
// ----------------------------------------------------------------------------
// vx_mem_rsp_pipe
//   Fixed-depth valid+payload shift pipe. It never stalls: every entry that
//   enters leaves exactly STAGES cycles later. Reset clears the valid bits
//   only; payload registers carry no reset.
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset (valids only)
//   i_valid  in   entry present this cycle
//   i_data   in   entry payload
//   o_valid  out  entry leaving the last stage
//   o_data   out  payload of the leaving entry
// ----------------------------------------------------------------------------
module vx_mem_rsp_pipe #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];

  // Stage 0 captures the input; stage s captures stage s-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int s = 1; s < STAGES; s++) begin
      r_data[s] <= r_data[s-1];
    end
  end

  // Last stage drives the pipe output.
  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/vx_mem_responder.sv
// ----------------------------------------------------------------------------
// vx_mem_responder
//   Memory-side endpoint of the mem req/rsp bus. Requests (rw, addr, byteen,
//   data, tag) are serviced from internal line storage; reads return tagged
//   responses strictly in order, at the earliest LATENCY cycles after the
//   request fired. Storage is not cleared by reset.
//   Optional feature: define VX_MEM_RESPONDER_WRITE_ACK_EN to make writes
//   return a response (their tag, data '0), ordered with reads and consuming
//   a credit. Without it writes are posted.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_req_valid/ready request handshake (ready depends on registered state)
//   mem_req_addr        line address (low log2(NUM_LINES) bits index storage)
//   mem_req_rw          1 = write, 0 = read
//   mem_req_byteen      per-byte write enables
//   mem_req_data        write data
//   mem_req_tag         request tag, returned verbatim
//   mem_rsp_valid/ready response handshake
//   mem_rsp_data        read data ('0 for write acks)
//   mem_rsp_tag         tag of the originating request
//   pending             responses outstanding (in pipe + queue)
// ----------------------------------------------------------------------------
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     mem_req_valid,
  input  logic [ADDR_WIDTH-1:0]                    mem_req_addr,
  input  logic                                     mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]                  mem_req_byteen,
  input  logic [DATA_WIDTH-1:0]                    mem_req_data,
  input  logic [TAG_WIDTH-1:0]                     mem_req_tag,
  output logic                                     mem_req_ready,
  output logic                                     mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]                    mem_rsp_data,
  output logic [TAG_WIDTH-1:0]                     mem_rsp_tag,
  input  logic                                     mem_rsp_ready,
  output logic [vx_pend_width(RSP_QUEUE_SIZE)-1:0] pending
);

  localparam int IDX_W  = vx_idx_width(NUM_LINES);
  localparam int PEND_W = vx_pend_width(RSP_QUEUE_SIZE);
  localparam int PTR_W  = $clog2(RSP_QUEUE_SIZE);
  localparam int BYTES  = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  logic                  w_req_fire;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_pipe_in_valid;
  rsp_entry_t            w_pipe_in;
  logic                  w_pipe_out_valid;
  rsp_entry_t            w_pipe_out;
  logic                  w_q_empty;
  logic                  w_q_push;
  logic                  w_q_pop;
  logic                  w_rsp_fire;
  rsp_entry_t            w_rsp_entry;

  logic [DATA_WIDTH-1:0] r_mem [NUM_LINES];
  logic [PEND_W-1:0]     r_pending;
  rsp_entry_t            r_q_mem [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0]      r_q_wr;
  logic [PTR_W-1:0]      r_q_rd;
  logic [PEND_W-1:0]     r_q_count;

  // Upper address bits alias onto the same lines by design.
  assign w_idx = mem_req_addr[IDX_W-1:0];
  if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];
  end

  // Credits cover both pipe and queue, so a request is only accepted when
  // its eventual response is guaranteed a queue slot.
  assign mem_req_ready = (r_pending < PEND_W'(RSP_QUEUE_SIZE));
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  // Line storage: per-byte write, no reset.
  always_ff @(posedge clk) begin
    if (w_req_fire && mem_req_rw) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) begin
          r_mem[w_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  // Read data is sampled in the fire cycle, so it reflects every write that
  // fired on an earlier edge.
  always_comb begin
    w_pipe_in      = '0;
    w_pipe_in.tag  = mem_req_tag;
`ifdef VX_MEM_RESPONDER_WRITE_ACK_EN
    w_pipe_in_valid = w_req_fire;
    if (!mem_req_rw) begin
      w_pipe_in.data = r_mem[w_idx];
    end
`else
    w_pipe_in_valid = w_req_fire && !mem_req_rw;
    w_pipe_in.data  = r_mem[w_idx];
`endif
  end

  vx_mem_rsp_pipe #(
    .STAGES (LATENCY),
    .WIDTH  ($bits(rsp_entry_t))
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_pipe_in_valid),
    .i_data  (w_pipe_in),
    .o_valid (w_pipe_out_valid),
    .o_data  (w_pipe_out)
  );

  // FWFT queue with bypass: when the queue is empty the pipe exit is
  // presented directly, which gives exactly LATENCY cycles for an idle
  // responder. An un-consumed pipe exit is pushed so it stays on the output
  // next cycle, keeping the payload stable under backpressure. Pipe entries
  // are always younger than queued ones, so ordering is preserved.
  assign w_q_empty     = (r_q_count == '0);
  assign mem_rsp_valid = !w_q_empty || w_pipe_out_valid;
  assign w_rsp_entry   = w_q_empty ? w_pipe_out : r_q_mem[r_q_rd];
  assign mem_rsp_data  = w_rsp_entry.data;
  assign mem_rsp_tag   = w_rsp_entry.tag;
  assign w_rsp_fire    = mem_rsp_valid && mem_rsp_ready;
  assign w_q_pop       = !w_q_empty && mem_rsp_ready;
  assign w_q_push      = w_pipe_out_valid && !(w_q_empty && mem_rsp_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_wr    <= '0;
      r_q_rd    <= '0;
      r_q_count <= '0;
    end else begin
      if (w_q_push) begin
        r_q_wr <= r_q_wr + PTR_W'(1);
      end
      if (w_q_pop) begin
        r_q_rd <= r_q_rd + PTR_W'(1);
      end
      r_q_count <= r_q_count + PEND_W'(w_q_push) - PEND_W'(w_q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_q_push) begin
      r_q_mem[r_q_wr] <= w_pipe_out;
    end
  end

  // Outstanding-response credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_pipe_in_valid && !w_rsp_fire) begin
      r_pending <= r_pending + PEND_W'(1);
    end else if (!w_pipe_in_valid && w_rsp_fire) begin
      r_pending <= r_pending - PEND_W'(1);
    end
  end

  assign pending = r_pending;

endmodule
